mem_stage_ctrl: RTL and testbench

Memory-stage controller for the 5-stage pipeline. It consumes the EX/MEM pipeline register outputs and runs the data-memory access through a req/ack handshake, stalling the upstream pipeline while the access is outstanding. It also holds the MEM/WB pipeline register that feeds write-back and forwarding. Data memory may take a variable number of cycles to answer.

---
 rtl/mem_stage_ctrl.sv | 169 ++++++++++++++++
 tb/tb_mem_stage_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_ctrl.sv
// Purpose: MEM stage control; runs data-memory req/ack accesses and holds the MEM/WB register.
// Latency: non-memory op 1 cycle; memory op 1 + ack-wait cycles + 1 DONE cycle; misaligned 2 cycles.
// Backpressure: asserts stall upstream while an access is being issued or awaited; aborts after TIMEOUT waits.
module mem_stage_ctrl #(
  parameter int              TIMEOUT  = 16,
  parameter int              DW       = 32,
  parameter logic [DW-1:0]   ERR_DATA = DW'(32'hDEADBEEF)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic [1:0]    WB_in,
  input  logic [2:0]    M_in,
  input  logic [DW-1:0] Alu_in,
  input  logic [DW-1:0] Store_data,
  input  logic [4:0]    Dest_reg,
  output logic          stall,
  output logic          mem_req,
  output logic          mem_we,
  output logic [DW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  output logic [1:0]    WB_out,
  output logic [DW-1:0] Read_datareg,
  output logic [DW-1:0] Alu_outreg,
  output logic [4:0]    Forwarding_out,
  output logic          mem_err,
  output logic          align_err
);

  localparam int             TW     = $clog2(TIMEOUT);
  localparam logic [TW-1:0]  T_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [TW-1:0]  timer;
  logic [DW-1:0]  rdata_buf;
  logic           access;
  logic           aligned;
  logic           timer_last;

  // Branch is resolved in EX; the bit travels with M_in but is not used here.
  logic           unused_branch;
  assign unused_branch = M_in[2];

  assign access     = M_in[1] | M_in[0];
  assign aligned    = (Alu_in[1:0] == 2'b00);
  assign timer_last = (timer == T_LAST);

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and stall; stall is never raised in DONE so the held instruction retires.
  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    case (state)
      S_IDLE: begin
        if (access) begin
          stall     = 1'b1;
          state_nxt = aligned ? S_WAIT : S_DONE;
        end
      end
      S_WAIT: begin
        stall = 1'b1;
        if (mem_ack || timer_last) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Memory request side: issue, hold stable during WAIT, capture the answer or the abort value.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      timer     <= '0;
      rdata_buf <= '0;
      mem_err   <= 1'b0;
      align_err <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (access && aligned) begin
            mem_req   <= 1'b1;
            mem_we    <= M_in[0];
            mem_addr  <= Alu_in;
            mem_wdata <= Store_data;
            timer     <= '0;
          end else if (access) begin
            align_err <= 1'b1;
            rdata_buf <= ERR_DATA;
          end
        end
        S_WAIT: begin
          if (mem_ack) begin
            rdata_buf <= mem_rdata;
            mem_req   <= 1'b0;
          end else if (timer_last) begin
            mem_req   <= 1'b0;
            mem_err   <= 1'b1;
            rdata_buf <= ERR_DATA;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // MEM/WB register: pass-through for non-memory ops, bubbles while busy, result in DONE.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      WB_out         <= '0;
      Read_datareg   <= '0;
      Alu_outreg     <= '0;
      Forwarding_out <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!access) begin
            WB_out         <= WB_in;
            Read_datareg   <= '0;
            Alu_outreg     <= Alu_in;
            Forwarding_out <= Dest_reg;
          end else begin
            WB_out <= '0;
          end
        end
        S_WAIT: begin
          WB_out <= '0;
        end
        S_DONE: begin
          WB_out         <= WB_in;
          Read_datareg   <= rdata_buf;
          Alu_outreg     <= Alu_in;
          Forwarding_out <= Dest_reg;
        end
        default: begin
          WB_out <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
module tb_mem_stage_ctrl;

  localparam int          TIMEOUT = 4;
  localparam int          DW      = 32;
  localparam logic [31:0] ERR     = 32'hDEADBEEF;

  logic          clock;
  logic          reset_n;
  logic [1:0]    WB_in;
  logic [2:0]    M_in;
  logic [DW-1:0] Alu_in;
  logic [DW-1:0] Store_data;
  logic [4:0]    Dest_reg;
  logic          stall;
  logic          mem_req;
  logic          mem_we;
  logic [DW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;
  logic [1:0]    WB_out;
  logic [DW-1:0] Read_datareg;
  logic [DW-1:0] Alu_outreg;
  logic [4:0]    Forwarding_out;
  logic          mem_err;
  logic          align_err;

  int checks = 0;
  int errors = 0;
  bit mem_err_m;
  bit align_err_m;

  mem_stage_ctrl #(.TIMEOUT(TIMEOUT), .DW(DW), .ERR_DATA(ERR)) dut (
    .clock(clock), .reset_n(reset_n),
    .WB_in(WB_in), .M_in(M_in), .Alu_in(Alu_in), .Store_data(Store_data), .Dest_reg(Dest_reg),
    .stall(stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .WB_out(WB_out), .Read_datareg(Read_datareg), .Alu_outreg(Alu_outreg),
    .Forwarding_out(Forwarding_out), .mem_err(mem_err), .align_err(align_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one instruction on EX/MEM (called at a falling edge), act as the data memory,
  // and hold the instruction until it retires; then compare against the expected outcome.
  // ack_at = WAIT cycle (1-based) in which memory answers; outside 1..TIMEOUT means never.
  task automatic run_instr(input logic [1:0] wb, input logic [2:0] m, input logic [31:0] alu,
                           input logic [31:0] sd, input logic [4:0] dest, input int ack_at,
                           input logic [31:0] rd, input bit spurious, input string name);
    bit          acc;
    bit          mis;
    int          exp_stall;
    logic [31:0] exp_read;
    int          stalls;
    int          waits;
    int          cyc;
    bit          retired;
    bit          bubble_ok;
    bit          req_ok;
    bit          req_seen;

    acc = m[1] | m[0];
    mis = (alu[1:0] != 2'b00);
    if (!acc) begin
      exp_stall = 0;
      exp_read  = 32'h0;
    end else if (mis) begin
      exp_stall   = 1;
      exp_read    = ERR;
      align_err_m = 1'b1;
    end else if (ack_at >= 1 && ack_at <= TIMEOUT) begin
      exp_stall = 1 + ack_at;
      exp_read  = rd;
    end else begin
      exp_stall = 1 + TIMEOUT;
      exp_read  = ERR;
      mem_err_m = 1'b1;
    end

    WB_in = wb; M_in = m; Alu_in = alu; Store_data = sd; Dest_reg = dest;
    stalls = 0; waits = 0; cyc = 0;
    retired = 1'b0; bubble_ok = 1'b1; req_ok = 1'b1; req_seen = 1'b0;

    while (!retired && cyc < 64) begin
      if (mem_req === 1'b1) begin
        waits++;
        req_seen  = 1'b1;
        mem_ack   = (waits == ack_at);
        mem_rdata = (waits == ack_at) ? rd : $urandom;
        if (mem_we !== m[0] || mem_addr !== alu || mem_wdata !== sd) req_ok = 1'b0;
      end else begin
        mem_ack   = spurious ? 1'($urandom_range(0, 1)) : 1'b0;
        mem_rdata = $urandom;
      end
      #1;
      if (cyc > 0 && WB_out !== 2'b00) bubble_ok = 1'b0;
      if (stall === 1'b1) stalls++;
      else retired = 1'b1;
      @(posedge clock);
      @(negedge clock);
      cyc++;
    end
    mem_ack = 1'b0;

    check({name, ".retire"},       64'(retired), 64'(1));
    check({name, ".stall_cycles"}, 64'(stalls), 64'(exp_stall));
    check({name, ".WB_out"},       64'(WB_out), 64'(wb));
    check({name, ".Read_datareg"}, 64'(Read_datareg), 64'(exp_read));
    check({name, ".Alu_outreg"},   64'(Alu_outreg), 64'(alu));
    check({name, ".Forwarding"},   64'(Forwarding_out), 64'(dest));
    check({name, ".mem_err"},      64'(mem_err), 64'(mem_err_m));
    check({name, ".align_err"},    64'(align_err), 64'(align_err_m));
    check({name, ".req_idle"},     64'(mem_req), 64'(0));
    if (acc && !mis) begin
      check({name, ".req_seen"},   64'(req_seen), 64'(1));
      check({name, ".req_fields"}, 64'(req_ok), 64'(1));
      check({name, ".wait_cycles"}, 64'(waits), 64'(exp_stall - 1));
    end
    if (acc && mis) check({name, ".no_req"}, 64'(req_seen), 64'(0));
    if (acc) check({name, ".bubble"}, 64'(bubble_ok), 64'(1));
  endtask

  initial begin
    logic [2:0]  rm;
    logic [31:0] ra;
    int          wcnt;

    reset_n = 1'b0;
    WB_in = '0; M_in = '0; Alu_in = '0; Store_data = '0; Dest_reg = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    mem_err_m = 1'b0; align_err_m = 1'b0;

    repeat (2) @(negedge clock);
    #1;
    check("rst.mem_req",   64'(mem_req), 64'(0));
    check("rst.mem_we",    64'(mem_we), 64'(0));
    check("rst.mem_addr",  64'(mem_addr), 64'(0));
    check("rst.mem_wdata", 64'(mem_wdata), 64'(0));
    check("rst.WB_out",    64'(WB_out), 64'(0));
    check("rst.Read_data", 64'(Read_datareg), 64'(0));
    check("rst.Alu_out",   64'(Alu_outreg), 64'(0));
    check("rst.Fwd",       64'(Forwarding_out), 64'(0));
    check("rst.errs",      64'({mem_err, align_err}), 64'(0));
    check("rst.stall",     64'(stall), 64'(0));
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    // Directed cases.
    run_instr(2'b10, 3'b000, 32'h5,   32'h0,  5'd3, 0, 32'h0, 1'b0, "alu");
    run_instr(2'b11, 3'b010, 32'h100, 32'h0,  5'd7, 3, 32'hCAFE0001, 1'b0, "load");
    run_instr(2'b00, 3'b001, 32'h8,   32'h55, 5'd0, 1, 32'h1234, 1'b0, "store");
    run_instr(2'b11, 3'b010, 32'h200, 32'h0,  5'd9, 0, 32'h0, 1'b0, "timeout");
    run_instr(2'b11, 3'b010, 32'h204, 32'h0,  5'd10, 2, 32'h600D600D, 1'b0, "load_after_to");
    run_instr(2'b11, 3'b010, 32'h102, 32'h0,  5'd11, 1, 32'h0, 1'b0, "misaligned");
    run_instr(2'b01, 3'b011, 32'h40,  32'hA5, 5'd12, 4, 32'h77, 1'b0, "both_bits_write");
    run_instr(2'b10, 3'b100, 32'h3,   32'h0,  5'd13, 0, 32'h0, 1'b1, "branch_only");

    // Randomized instruction stream, back-to-back, with spurious acks outside WAIT.
    for (int i = 0; i < 40; i++) begin
      rm = 3'($urandom_range(0, 7));
      ra = $urandom;
      if ($urandom_range(0, 3) != 0) ra[1:0] = 2'b00;
      run_instr(2'($urandom), rm, ra, $urandom, 5'($urandom),
                $urandom_range(1, TIMEOUT + 1), $urandom, 1'b1, "rand");
    end

    // Reset in the middle of an access.
    WB_in = 2'b11; M_in = 3'b010; Alu_in = 32'h300; Dest_reg = 5'd4;
    wcnt = 0;
    while (mem_req !== 1'b1 && wcnt < 8) begin
      @(posedge clock);
      @(negedge clock);
      wcnt++;
    end
    check("midwait.req_up", 64'(mem_req), 64'(1));
    reset_n = 1'b0;
    M_in = 3'b000;
    #1;
    check("midwait.mem_req", 64'(mem_req), 64'(0));
    check("midwait.WB_out",  64'(WB_out), 64'(0));
    check("midwait.stall",   64'(stall), 64'(0));
    check("midwait.errs",    64'({mem_err, align_err}), 64'(0));
    mem_err_m = 1'b0; align_err_m = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    run_instr(2'b10, 3'b000, 32'h5, 32'h0, 5'd3, 0, 32'h0, 1'b0, "alu_after_rst");
    run_instr(2'b11, 3'b010, 32'h10, 32'h0, 5'd6, 1, 32'hBEEF, 1'b0, "load_after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
